// File: rtl/wb_sram_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone SRAM arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package wb_sram_arb_pkg;

  // Arbiter FSM: IDLE is the one-cycle bubble between grants, BUSY forwards the granted cycle.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Current owner of the slave port.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_M0   = 2'd1,
    GNT_M1   = 2'd2
  } gnt_t;

  // Default number of BUSY cycles without an ack before the cycle is errored out.
  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/wb_arb_timeout_cnt.sv
// Bus-timeout counter: counts BUSY cycles without a slave ack and flags the last allowed one.
// Latency: expired is combinational from the registered count.
// Backpressure: none; the count saturates at TIMEOUT-1 until cleared.
module wb_arb_timeout_cnt
  import wb_sram_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Count enabled cycles from zero; hold at the terminal value so it never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/wb_sram_arbiter.sv
// Round-robin 2:1 Wishbone classic arbiter in front of the on-chip SRAM, with bus timeout.
// Latency: stb to slave one cycle after request; ack/err routed back combinationally.
// Backpressure: the losing master waits (no ack) until the mandatory IDLE bubble after the winner ends.
module wb_sram_arbiter
  import wb_sram_arb_pkg::*;
#(
  parameter int ADR_W   = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [3:0]       m0_sel_i,
  input  logic [31:0]      m0_dat_i,
  output logic [31:0]      m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [3:0]       m1_sel_i,
  input  logic [31:0]      m1_dat_i,
  output logic [31:0]      m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [3:0]       s_sel_o,
  output logic [31:0]      s_dat_o,
  input  logic [31:0]      s_dat_i,
  input  logic             s_ack_i
);

  arb_state_t state;
  gnt_t       gnt;
  logic       prio_m1;   // 1: m1 wins the next tie, 0: m0 wins it

  logic m0_req;
  logic m1_req;
  logic busy;
  logic sel_req;
  logic tmo_expired;
  logic tmo_fire;
  logic term_ok;

  assign m0_req = m0_cyc_i & m0_stb_i;
  assign m1_req = m1_cyc_i & m1_stb_i;
  assign busy   = (state == BUSY);

  // Request of whichever master currently owns the slave.
  always_comb begin
    sel_req = 1'b0;
    case (gnt)
      GNT_M0:  sel_req = m0_req;
      GNT_M1:  sel_req = m1_req;
      default: sel_req = 1'b0;
    endcase
  end

  // Timeout only terminates a live cycle; an ack in the same cycle takes precedence.
  assign tmo_fire = busy & sel_req & ~s_ack_i & tmo_expired;

  // Counter is held at zero in IDLE so every BUSY entry starts counting from zero.
  wb_arb_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (state == IDLE),
    .en     (busy & ~s_ack_i),
    .expired(tmo_expired)
  );

  // Arbitration FSM: grant in IDLE, leave BUSY on ack, timeout or abort.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      gnt     <= GNT_NONE;
      prio_m1 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req && (!m1_req || !prio_m1)) begin
            gnt   <= GNT_M0;
            state <= BUSY;
          end else if (m1_req) begin
            gnt   <= GNT_M1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (s_ack_i || tmo_fire) begin
            // Completed or timed out: the other master gets the next tie.
            prio_m1 <= (gnt == GNT_M0);
            gnt     <= GNT_NONE;
            state   <= IDLE;
          end else if (!sel_req) begin
            // Master abandoned the cycle: no termination, priority untouched.
            gnt   <= GNT_NONE;
            state <= IDLE;
          end
        end
        default: begin
          gnt   <= GNT_NONE;
          state <= IDLE;
        end
      endcase
    end
  end

  // Slave side: forward the granted master only while BUSY, otherwise park at zero.
  always_comb begin
    s_cyc_o = busy & sel_req;
    s_stb_o = busy & sel_req;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    if (busy) begin
      if (gnt == GNT_M1) begin
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_sel_o = m1_sel_i;
        s_dat_o = m1_dat_i;
      end else begin
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_sel_o = m0_sel_i;
        s_dat_o = m0_dat_i;
      end
    end
  end

  // Terminations are suppressed during reset so a slave ack racing the reset is dropped.
  assign term_ok = busy & ~rst_i;

  assign m0_ack_o = term_ok & (gnt == GNT_M0) & s_ack_i;
  assign m1_ack_o = term_ok & (gnt == GNT_M1) & s_ack_i;
  assign m0_err_o = term_ok & (gnt == GNT_M0) & tmo_fire;
  assign m1_err_o = term_ok & (gnt == GNT_M1) & tmo_fire;

  // Read data goes to both masters; only the acked one samples it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule
